gpio_irq_controller: RTL and testbench
======================================

// Module: gpio_irq_controller
// PURPOSE
//  Consumer of the per-pin rising/falling edge-detected strobes from the GPIO edge detector.
//  Latches them into a sticky pending register with write-1-to-clear access and a per-pin
//  enable mask, and tracks overruns (an event on a pin that is already pending).
//  Drives one level IRQ line to the core, with a programmable hold-off gap between assertions.
// PARAMETERS
//  WIDTH      32  number of GPIO pins / width of all per-pin vectors
//  HOLDOFF_W  16  width of the hold-off cycle count
// PORTS
//  clk             in   1          system clock
//  rst_n           in   1          synchronous reset, active low
//  rise_detected   in   WIDTH      per-pin rising-edge event, single-cycle or level (OR'd each cycle)
//  fall_detected   in   WIDTH      per-pin falling-edge event
//  ier_wr          in   1          write strobe for enable register
//  ier_wdata       in   WIDTH      new enable mask (full overwrite)
//  isr_clr         in   1          W1C strobe for pending and overrun registers
//  isr_clr_mask    in   WIDTH      bits to clear (1 = clear)
//  holdoff         in   HOLDOFF_W  minimum irq-low cycles after deassertion; 0 = no gap
//  ier             out  WIDTH      enable register
//  isr             out  WIDTH      pending register
//  ovr             out  WIDTH      overrun register
//  irq             out  1          interrupt request to core, registered
// BEHAVIOUR
//  Reset: clk-synchronous while rst_n=0; ier, isr, ovr = 0; irq = 0; FSM = IDLE; counter = 0.
//    Reset mid-operation (any state, count) aborts cleanly to these values on the next edge.
//  evt[i] = rise_detected[i] | fall_detected[i].
//  isr[i]: next = evt[i] | (isr[i] & ~(isr_clr & isr_clr_mask[i])). Set wins over clear in the
//    same cycle. Update is visible one cycle after the strobe or event.
//  ovr[i]: set when evt[i] & isr[i] (pre-update value), including when the same cycle clears
//    that bit. Cleared by the same W1C strobe/mask; set wins over clear.
//  ier: loaded from ier_wdata on ier_wr, one-cycle latency. Masking does not stop latching:
//    isr/ovr record events regardless of ier.
//  active = |(isr & ier), using registered values.
//  FSM (irq is the registered decode of the state: 1 only in ASSERT):
//    IDLE:    active -> ASSERT.
//    ASSERT:  !active & holdoff==0 -> IDLE.
//             !active & holdoff!=0 -> HOLDOFF, cnt <= holdoff-1.
//             active -> stay.
//    HOLDOFF: cnt==0 -> IDLE; else cnt <= cnt-1. Events still latch into isr.
//             The count is not restarted or shortened by active.
//  Latency: event at edge N -> isr at N+1 -> irq high at N+2.
//    W1C clearing the last active bit at N -> isr clear at N+1 -> irq low at N+2.
//  Hold-off length: irq stays low exactly `holdoff` cycles before IDLE is re-entered.
//    If still active in IDLE, irq rises one cycle later.
//    `holdoff` is sampled only on the ASSERT->HOLDOFF transition.
//  Enable write to 0 while in ASSERT also deasserts (same path as W1C).
//  Illegal state encoding -> IDLE.
// STRUCTURE
//  gpio_pkg gets:
//    gpio_irq_state_t enum {GPIO_IRQ_IDLE, GPIO_IRQ_ASSERT, GPIO_IRQ_HOLDOFF};
//    GPIO_IRQ_HOLDOFF_W localparam (default 16).
//  One sub-module: gpio_irq_holdoff_timer. It does load/decrement/zero-flag and is owned by the FSM.
//  Pending/overrun/enable registers live in the top level.
// TESTING
//  1. Reset: drive events and writes with rst_n=0 -> ier=isr=ovr=0, irq=0 on every cycle.
//  2. Basic flow: ier=0x1, rise_detected=0x1 for 1 cycle at N -> isr=0x1 at N+1, irq=1 at N+2;
//     isr_clr with mask 0x1 at M -> irq=0 at M+2.
//  3. Set/clear collision: isr=0x4, same cycle fall_detected=0x4 and W1C mask 0x4
//     -> isr stays 0x4, ovr=0x4, irq stays 1.
//  4. Hold-off: holdoff=5, new event during the gap -> irq low exactly 5 cycles, then re-asserts 1 cycle later;
//     holdoff=0 -> irq low 1 cycle minimum (IDLE pass).
//  5. Masking: ier=0, event on pin 7 -> isr=0x80, irq=0; write ier=0x80 -> irq=1 two cycles after write.
//  6. Reset mid-HOLDOFF (cnt=3) and mid-ASSERT -> next cycle IDLE, all registers 0, no spurious irq.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO interrupt controller.
package gpio_pkg;

  localparam int GPIO_IRQ_HOLDOFF_W = 16;

  typedef enum logic [1:0] {
    GPIO_IRQ_IDLE    = 2'd0,
    GPIO_IRQ_ASSERT  = 2'd1,
    GPIO_IRQ_HOLDOFF = 2'd2
  } gpio_irq_state_t;

endpackage

// File: rtl/gpio_irq_controller_if.sv
// Register/event bundle between the GPIO edge detector, CSR block and the irq controller.
interface gpio_irq_controller_if #(
  parameter int WIDTH     = 32,
  parameter int HOLDOFF_W = 16
);
  logic [WIDTH-1:0]     rise_detected;
  logic [WIDTH-1:0]     fall_detected;
  logic                 ier_wr;
  logic [WIDTH-1:0]     ier_wdata;
  logic                 isr_clr;
  logic [WIDTH-1:0]     isr_clr_mask;
  logic [HOLDOFF_W-1:0] holdoff;
  logic [WIDTH-1:0]     ier;
  logic [WIDTH-1:0]     isr;
  logic [WIDTH-1:0]     ovr;
  logic                 irq;

  modport master (
    output rise_detected, fall_detected, ier_wr, ier_wdata, isr_clr, isr_clr_mask, holdoff,
    input  ier, isr, ovr, irq
  );

  modport slave (
    input  rise_detected, fall_detected, ier_wr, ier_wdata, isr_clr, isr_clr_mask, holdoff,
    output ier, isr, ovr, irq
  );
endinterface

// File: rtl/gpio_irq_holdoff_timer.sv
// Down-counter for the irq hold-off gap; loaded with (holdoff-1) and stepped by the FSM.
module gpio_irq_holdoff_timer #(
  parameter int HOLDOFF_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [HOLDOFF_W-1:0] load_val,
  input  logic                 dec,
  output logic                 zero
);
  localparam logic [HOLDOFF_W-1:0] ONE = {{(HOLDOFF_W-1){1'b0}}, 1'b1};

  logic [HOLDOFF_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val - ONE;
    end else if (dec) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/gpio_irq_controller.sv
// Sticky pending/overrun latching with W1C and enable mask, driving one level irq
// with a programmable low gap after each deassertion.
module gpio_irq_controller
  import gpio_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int HOLDOFF_W = GPIO_IRQ_HOLDOFF_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gpio_irq_controller_if.slave  bus
);
  localparam logic [1:0] ST_IDLE    = GPIO_IRQ_IDLE;
  localparam logic [1:0] ST_ASSERT  = GPIO_IRQ_ASSERT;
  localparam logic [1:0] ST_HOLDOFF = GPIO_IRQ_HOLDOFF;

  logic [WIDTH-1:0] ier_q, isr_q, ovr_q;
  logic [WIDTH-1:0] evt, clr;
  logic             active;
  logic [1:0]       state_q, state_d;
  logic             irq_q;
  logic             tmr_load, tmr_dec, tmr_zero;

  assign evt    = bus.rise_detected | bus.fall_detected;
  assign clr    = {WIDTH{bus.isr_clr}} & bus.isr_clr_mask;
  assign active = |(isr_q & ier_q);

  // A new event always wins over a simultaneous clear; overrun uses the pre-update isr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ier_q <= '0;
      isr_q <= '0;
      ovr_q <= '0;
    end else begin
      if (bus.ier_wr) begin
        ier_q <= bus.ier_wdata;
      end
      isr_q <= evt | (isr_q & ~clr);
      ovr_q <= (evt & isr_q) | (ovr_q & ~clr);
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (active) begin
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (!active) begin
          if (bus.holdoff == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_HOLDOFF;
            tmr_load = 1'b1;
          end
        end
      end
      ST_HOLDOFF: begin
        if (tmr_zero) begin
          state_d = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // irq is flopped from the next-state decode so it is glitch-free and tracks state exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= (state_d == ST_ASSERT);
    end
  end

  gpio_irq_holdoff_timer #(
    .HOLDOFF_W (HOLDOFF_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (bus.holdoff),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  assign bus.ier = ier_q;
  assign bus.isr = isr_q;
  assign bus.ovr = ovr_q;
  assign bus.irq = irq_q;
endmodule

// File: tb/tb_gpio_irq_controller.sv
// Directed vector table plus hand sequences for hold-off timing and mid-operation reset.
module tb_gpio_irq_controller;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   low;

  gpio_irq_controller_if #(.WIDTH(32), .HOLDOFF_W(16)) bus ();

  gpio_irq_controller #(
    .WIDTH     (32),
    .HOLDOFF_W (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] rise;
    logic [31:0] fall;
    logic        wr;
    logic [31:0] wdata;
    logic        clr;
    logic [31:0] mask;
    logic [31:0] e_ier;
    logic [31:0] e_isr;
    logic [31:0] e_ovr;
    logic        e_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge take them, sample #1 later, then drop the pulses.
  task automatic drive(input logic rst, input logic [31:0] rise, input logic [31:0] fall,
                       input logic wr, input logic [31:0] wdata,
                       input logic clr, input logic [31:0] mask);
    rst_n             = rst;
    bus.rise_detected = rise;
    bus.fall_detected = fall;
    bus.ier_wr        = wr;
    bus.ier_wdata     = wdata;
    bus.isr_clr       = clr;
    bus.isr_clr_mask  = mask;
    @(posedge clk);
    #1;
    bus.rise_detected = '0;
    bus.fall_detected = '0;
    bus.ier_wr        = 1'b0;
    bus.ier_wdata     = '0;
    bus.isr_clr       = 1'b0;
    bus.isr_clr_mask  = '0;
  endtask

  task automatic idle();
    drive(1'b1, 0, 0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    drive(v.rst, v.rise, v.fall, v.wr, v.wdata, v.clr, v.mask);
    check_output($sformatf("v%0d_ier", idx), bus.ier, v.e_ier);
    check_output($sformatf("v%0d_isr", idx), bus.isr, v.e_isr);
    check_output($sformatf("v%0d_ovr", idx), bus.ovr, v.e_ovr);
    check_output($sformatf("v%0d_irq", idx), {31'b0, bus.irq}, {31'b0, v.e_irq});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.rise_detected = '0;
    bus.fall_detected = '0;
    bus.ier_wr        = 1'b0;
    bus.ier_wdata     = '0;
    bus.isr_clr       = 1'b0;
    bus.isr_clr_mask  = '0;
    bus.holdoff       = '0;

    //                rst rise   fall  wr wdata     clr mask   ier    isr    ovr   irq
    vecs.push_back('{1'b0, 32'hff, 0, 1'b1, 32'hffff, 1'b0, 0,  0,     0,     0,    1'b0});
    vecs.push_back('{1'b0, 0, 32'hf, 1'b1, 32'h1,     1'b1, 1,  0,     0,     0,    1'b0});
    vecs.push_back('{1'b1, 0, 0,     1'b1, 32'h1,     1'b0, 0,  1,     0,     0,    1'b0});
    vecs.push_back('{1'b1, 1, 0,     1'b0, 0,         1'b0, 0,  1,     1,     0,    1'b0});
    vecs.push_back('{1'b1, 0, 0,     1'b0, 0,         1'b0, 0,  1,     1,     0,    1'b1});
    vecs.push_back('{1'b1, 1, 0,     1'b0, 0,         1'b0, 0,  1,     1,     1,    1'b1});
    vecs.push_back('{1'b1, 0, 0,     1'b0, 0,         1'b1, 1,  1,     0,     0,    1'b1});
    vecs.push_back('{1'b1, 0, 0,     1'b0, 0,         1'b0, 0,  1,     0,     0,    1'b0});
    vecs.push_back('{1'b1, 0, 0,     1'b1, 32'h4,     1'b0, 0,  4,     0,     0,    1'b0});
    vecs.push_back('{1'b1, 0, 4,     1'b0, 0,         1'b0, 0,  4,     4,     0,    1'b0});
    vecs.push_back('{1'b1, 0, 0,     1'b0, 0,         1'b0, 0,  4,     4,     0,    1'b1});
    vecs.push_back('{1'b1, 0, 4,     1'b0, 0,         1'b1, 4,  4,     4,     4,    1'b1});
    vecs.push_back('{1'b1, 0, 0,     1'b0, 0,         1'b0, 0,  4,     4,     4,    1'b1});
    vecs.push_back('{1'b1, 0, 0,     1'b0, 0,         1'b1, 4,  4,     0,     0,    1'b1});
    vecs.push_back('{1'b1, 0, 0,     1'b0, 0,         1'b0, 0,  4,     0,     0,    1'b0});
    vecs.push_back('{1'b1, 0, 0,     1'b1, 0,         1'b0, 0,  0,     0,     0,    1'b0});
    vecs.push_back('{1'b1, 32'h80, 0, 1'b0, 0,        1'b0, 0,  0,     32'h80, 0,   1'b0});
    vecs.push_back('{1'b1, 0, 0,     1'b0, 0,         1'b0, 0,  0,     32'h80, 0,   1'b0});
    vecs.push_back('{1'b1, 0, 0,     1'b1, 32'h80,    1'b0, 0,  32'h80, 32'h80, 0,  1'b0});
    vecs.push_back('{1'b1, 0, 0,     1'b0, 0,         1'b0, 0,  32'h80, 32'h80, 0,  1'b1});
    vecs.push_back('{1'b1, 0, 0,     1'b1, 0,         1'b0, 0,  0,     32'h80, 0,   1'b1});
    vecs.push_back('{1'b1, 0, 0,     1'b0, 0,         1'b0, 0,  0,     32'h80, 0,   1'b0});
    vecs.push_back('{1'b1, 0, 0,     1'b0, 0,         1'b1, 32'h80, 0, 0,     0,    1'b0});

    foreach (vecs[i]) apply_stimulus(vecs[i], i);

    // Hold-off of 5: six low samples (five gap cycles plus the IDLE pass); holdoff changed mid-gap.
    bus.holdoff = 16'd5;
    drive(1'b1, 0, 0, 1'b1, 32'h1, 1'b0, 0);
    drive(1'b1, 1, 0, 1'b0, 0, 1'b0, 0);
    idle();
    check_output("ho5_assert", {31'b0, bus.irq}, 32'd1);
    drive(1'b1, 0, 0, 1'b0, 0, 1'b1, 1);
    check_output("ho5_clr_edge", {31'b0, bus.irq}, 32'd1);
    low = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 1) begin
        bus.holdoff = 16'd0;
        drive(1'b1, 1, 0, 1'b0, 0, 1'b0, 0);
      end else begin
        idle();
      end
      if (bus.irq) break;
      low++;
    end
    check_output("ho5_low_cycles", low, 32'd6);
    check_output("ho5_isr_gap_event", bus.isr, 32'h1);

    // Hold-off of 0: a single IDLE cycle low before re-asserting.
    drive(1'b1, 0, 0, 1'b0, 0, 1'b1, 1);
    check_output("ho0_clr_edge", {31'b0, bus.irq}, 32'd1);
    low = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) drive(1'b1, 1, 0, 1'b0, 0, 1'b0, 0);
      else        idle();
      if (bus.irq) break;
      low++;
    end
    check_output("ho0_low_cycles", low, 32'd1);

    // Reset in the middle of a hold-off gap.
    bus.holdoff = 16'd5;
    drive(1'b1, 0, 0, 1'b0, 0, 1'b1, 1);
    idle();
    idle();
    check_output("pre_rst_gap_irq", {31'b0, bus.irq}, 32'd0);
    drive(1'b0, 32'h3, 32'h10, 1'b1, 32'hff, 1'b0, 0);
    check_output("rst_gap_ier", bus.ier, 0);
    check_output("rst_gap_isr", bus.isr, 0);
    check_output("rst_gap_ovr", bus.ovr, 0);
    check_output("rst_gap_irq", {31'b0, bus.irq}, 0);
    for (int i = 0; i < 8; i++) begin
      idle();
      check_output($sformatf("post_rst_gap_irq%0d", i), {31'b0, bus.irq}, 0);
    end
    check_output("post_rst_gap_isr", bus.isr, 0);

    // Reset while asserted.
    drive(1'b1, 0, 0, 1'b1, 32'h2, 1'b0, 0);
    drive(1'b1, 0, 32'h2, 1'b0, 0, 1'b0, 0);
    idle();
    check_output("mid_assert_irq", {31'b0, bus.irq}, 32'd1);
    drive(1'b0, 32'h2, 0, 1'b0, 0, 1'b0, 0);
    check_output("rst_assert_ier", bus.ier, 0);
    check_output("rst_assert_isr", bus.isr, 0);
    check_output("rst_assert_ovr", bus.ovr, 0);
    check_output("rst_assert_irq", {31'b0, bus.irq}, 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check_output($sformatf("post_rst_assert_irq%0d", i), {31'b0, bus.irq}, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
